escrita_banco: RTL and testbench
================================

ESCRITA_BANCO -- requirements
Module: escrita_banco

Interface
REQ-001 Parameter: DEPTH, 2, write-request queue depth in entries; legal values 2 or 4 only.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-004 wr_valid  input  1  write request present.
REQ-005 wr_ready  output  1  queue can accept a request this cycle.
REQ-006 wr_addr  input  3  destination register index 0..7.
REQ-007 wr_data  input  4  result value from the ALU.
REQ-008 hold  input  1  freeze draining of the queue (pipeline stall).
REQ-009 rd_addr_a  input  3  read port A index.
REQ-010 rd_addr_b  input  3  read port B index.
REQ-011 rd_data_a  output  3  registered read data, port A.
REQ-012 rd_data_b  output  3  registered read data, port B.
REQ-013 pending  output  3  number of queued, not-yet-written requests (0..DEPTH).
REQ-014 wr_done  output  1  one-cycle pulse: a register was updated this edge.
REQ-015 ovf  output  1  sticky: some accepted request had wr_data[3]=1.

Function
REQ-016 Block SHALL hold eight 3-bit registers and write them only from the queue head.
REQ-017 Handshake: request accepted on a rising edge where wr_valid=1 and wr_ready=1; wr_addr/wr_data captured at that edge.
REQ-018 wr_ready SHALL equal (pending < DEPTH) combinationally from registered count, and SHALL be 0 while rst_n=0; a same-cycle drain does not raise wr_ready when full.
REQ-019 wr_valid with wr_ready=0 SHALL be ignored with no state change; requester keeps request stable until accepted.
REQ-020 Stored value SHALL be wr_data[2:0]; accepting a request with wr_data[3]=1 SHALL set ovf at that edge; ovf clears only on reset.
REQ-021 FSM states: IDLE (pending=0), DRAIN (pending>0, hold=0), HOLD (pending>0, hold=1); transitions evaluated every edge from next pending and hold.
REQ-022 In DRAIN, each edge SHALL pop the head and write it: regs[addr] <= data; exactly one write per cycle maximum.
REQ-023 In HOLD or IDLE no register write and no pop SHALL occur; accepts continue while wr_ready=1.
REQ-024 Latency: request accepted at edge N with empty queue and hold=0 SHALL be written at edge N+1, wr_done=1 in cycle after N+1.
REQ-025 Simultaneous accept and pop SHALL leave pending unchanged; order strictly FIFO.
REQ-026 Writes to address 0 SHALL be popped and discarded (regs[0] stays 0) and SHALL NOT pulse wr_done.
REQ-027 Consecutive writes to the same address SHALL all be applied in order; last one wins.
REQ-028 Reads: rd_data_x <= regs[rd_addr_x] at every edge (1-cycle latency), write-first: if the same edge writes that address, the new value is returned.
REQ-029 Queue pointers SHALL wrap modulo DEPTH; pending never exceeds DEPTH nor underflows.

Reset
REQ-030 On an edge with rst_n=0: regs[i] <= i for i=0..7, queue emptied, pending=0, FSM=IDLE, rd_data_a=rd_data_b=0, wr_done=0, ovf=0.
REQ-031 Reset mid-operation SHALL discard all queued requests without writing them; a request presented during reset is not accepted.
REQ-032 First accept possible on the first edge with rst_n=1.

Verification
REQ-033 Reset, then rd_addr_a=5, rd_addr_b=3 -> next cycle rd_data_a=3'b101, rd_data_b=3'b011, pending=0, wr_ready=1.
REQ-034 Accept addr=2 data=4'b0110 at edge N, hold=0 -> regs[2]=3'b110 at N+1, wr_done pulse, rd_addr_a=2 sampled at N+1 returns 3'b110, ovf=0.
REQ-035 hold=1, DEPTH=2, three back-to-back requests (4<-1, 5<-2, 6<-3) -> first two accepted, pending=2, wr_ready=0, third stalls; release hold -> writes 4,5,6 in order over three edges, pending returns to 0.
REQ-036 Accept addr=7 data=4'b1010 -> regs[7]=3'b010, ovf=1 and stays 1 after further clean writes until rst_n=0.
REQ-037 Accept addr=0 data=4'b0111 -> regs[0] remains 0, no wr_done, pending decrements normally.
REQ-038 hold=1, queue 2 requests, assert rst_n=0 one cycle -> pending=0, regs restored to index values, no queued write ever applied.

Source files
------------

// File: rtl/escrita_banco.sv
// escrita_banco: eight 3-bit registers written in FIFO order from a small
// write-request queue, with two registered write-first read ports.
module escrita_banco #(
    parameter int DEPTH = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       wr_valid_i,
    output logic       wr_ready_o,
    input  logic [2:0] wr_addr_i,
    input  logic [3:0] wr_data_i,
    input  logic       hold_i,
    input  logic [2:0] rd_addr_a_i,
    input  logic [2:0] rd_addr_b_i,
    output logic [2:0] rd_data_a_o,
    output logic [2:0] rd_data_b_o,
    output logic [2:0] pending_o,
    output logic       wr_done_o,
    output logic       ovf_o
);
    localparam int PW = (DEPTH > 2) ? 2 : 1;
    typedef enum logic [1:0] {IDLE, DRAIN, HOLD} state_t;
    state_t        state_q, state_d;
    logic [2:0]    regs_q [8];
    logic [2:0]    qaddr_q [DEPTH];
    logic [2:0]    qdata_q [DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [2:0]    count_q, count_d;
    logic [2:0]    rd_a_q, rd_b_q;
    logic          done_q, ovf_q;
    logic          accept, pop, wen;
    logic [2:0]    waddr, wdata;
    assign wr_ready_o  = rst_ni && (count_q < 3'(DEPTH));
    assign accept      = wr_valid_i && wr_ready_o;
    // DRAIN is only entered with a non-empty queue, so the head is always valid here
    assign pop         = state_q == DRAIN;
    assign waddr       = qaddr_q[head_q];
    assign wdata       = qdata_q[head_q];
    assign wen         = pop && waddr != 3'd0;
    assign rd_data_a_o = rd_a_q;
    assign rd_data_b_o = rd_b_q;
    assign pending_o   = count_q;
    assign wr_done_o   = done_q;
    assign ovf_o       = ovf_q;
    always_comb begin
        count_d = count_q + 3'(accept) - 3'(pop);
        state_d = (count_d == 3'd0) ? IDLE : hold_i ? HOLD : DRAIN;
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < 8; i++) regs_q[i] <= 3'(i);
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= IDLE;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (accept) begin
                qaddr_q[tail_q] <= wr_addr_i;
                qdata_q[tail_q] <= wr_data_i[2:0];
                tail_q          <= tail_q + PW'(1);
            end
            if (pop) head_q <= head_q + PW'(1);
            if (wen) regs_q[waddr] <= wdata;
            rd_a_q  <= (wen && waddr == rd_addr_a_i) ? wdata : regs_q[rd_addr_a_i];
            rd_b_q  <= (wen && waddr == rd_addr_b_i) ? wdata : regs_q[rd_addr_b_i];
            done_q  <= wen;
            ovf_q   <= ovf_q | (accept & wr_data_i[3]);
            count_q <= count_d;
            state_q <= state_d;
        end
    end
endmodule

// File: tb/tb_escrita_banco.sv
// tb_escrita_banco: table-driven cycle vectors for escrita_banco (DEPTH=2)
// plus a hand-written same-address drain sequence.
module tb_escrita_banco;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0, wr_valid = 1'b0, hold = 1'b0;
    logic [2:0] wr_addr = '0, rd_addr_a = '0, rd_addr_b = '0;
    logic [3:0] wr_data = '0;
    logic       wr_ready, wr_done, ovf;
    logic [2:0] rd_data_a, rd_data_b, pending;
    int         checks = 0, failures = 0;

    escrita_banco #(.DEPTH(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
        .wr_addr_i(wr_addr), .wr_data_i(wr_data), .hold_i(hold),
        .rd_addr_a_i(rd_addr_a), .rd_addr_b_i(rd_addr_b),
        .rd_data_a_o(rd_data_a), .rd_data_b_o(rd_data_b),
        .pending_o(pending), .wr_done_o(wr_done), .ovf_o(ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst_n, v;
        logic [2:0] a;
        logic [3:0] d;
        logic       h;
        logic [2:0] ra, rb, ea, eb, ep;
        logic       er, ed, eo;
    } vec_t;

    function automatic vec_t mk(input logic r, v, input logic [2:0] a, input logic [3:0] d,
                                input logic h, input logic [2:0] ra, rb, ea, eb, ep,
                                input logic er, ed, eo);
        return '{r, v, a, d, h, ra, rb, ea, eb, ep, er, ed, eo};
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%0d expected=%0d", name, idx, act, exp);
        end
    endtask

    vec_t tbl [24];

    initial begin
        //            rst v a  d  h  ra rb ea eb ep rdy done ovf
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 5, 3, 5, 3, 0, 1, 0, 0);
        tbl[2]  = mk(1, 1, 2, 6, 0, 2, 3, 2, 3, 1, 1, 0, 0);
        tbl[3]  = mk(1, 0, 0, 0, 0, 2, 2, 6, 6, 0, 1, 1, 0);
        tbl[4]  = mk(1, 0, 0, 0, 0, 2, 0, 6, 0, 0, 1, 0, 0);
        tbl[5]  = mk(1, 1, 4, 1, 1, 4, 5, 4, 5, 1, 1, 0, 0);
        tbl[6]  = mk(1, 1, 5, 2, 1, 4, 5, 4, 5, 2, 0, 0, 0);
        tbl[7]  = mk(1, 1, 6, 3, 1, 4, 6, 4, 6, 2, 0, 0, 0);
        tbl[8]  = mk(1, 1, 6, 3, 0, 4, 6, 4, 6, 2, 0, 0, 0);
        tbl[9]  = mk(1, 1, 6, 3, 0, 4, 6, 1, 6, 1, 1, 1, 0);
        tbl[10] = mk(1, 1, 6, 3, 0, 5, 4, 2, 1, 1, 1, 1, 0);
        tbl[11] = mk(1, 0, 0, 0, 0, 6, 5, 3, 2, 0, 1, 1, 0);
        tbl[12] = mk(1, 0, 0, 0, 0, 4, 6, 1, 3, 0, 1, 0, 0);
        tbl[13] = mk(1, 1, 7, 10, 0, 7, 0, 7, 0, 1, 1, 0, 1);
        tbl[14] = mk(1, 1, 1, 5, 0, 7, 1, 2, 1, 1, 1, 1, 1);
        tbl[15] = mk(1, 0, 0, 0, 0, 1, 7, 5, 2, 0, 1, 1, 1);
        tbl[16] = mk(1, 1, 0, 7, 0, 0, 1, 0, 5, 1, 1, 0, 1);
        tbl[17] = mk(1, 0, 0, 0, 0, 0, 1, 0, 5, 0, 1, 0, 1);
        tbl[18] = mk(1, 1, 3, 1, 1, 3, 2, 3, 6, 1, 1, 0, 1);
        tbl[19] = mk(1, 1, 2, 7, 1, 3, 2, 3, 6, 2, 0, 0, 1);
        tbl[20] = mk(0, 1, 2, 7, 1, 3, 2, 0, 0, 0, 0, 0, 0);
        tbl[21] = mk(1, 1, 5, 3, 0, 3, 2, 3, 2, 1, 1, 0, 0);
        tbl[22] = mk(1, 0, 0, 0, 0, 7, 5, 7, 3, 0, 1, 1, 0);
        tbl[23] = mk(1, 0, 0, 0, 0, 1, 4, 1, 4, 0, 1, 0, 0);

        for (int i = 0; i < 24; i++) begin
            rst_n = tbl[i].rst_n; wr_valid = tbl[i].v; wr_addr = tbl[i].a;
            wr_data = tbl[i].d; hold = tbl[i].h;
            rd_addr_a = tbl[i].ra; rd_addr_b = tbl[i].rb;
            @(posedge clk); #1;
            chk("rd_data_a", i, rd_data_a, tbl[i].ea);
            chk("rd_data_b", i, rd_data_b, tbl[i].eb);
            chk("pending",   i, pending,   tbl[i].ep);
            chk("wr_ready",  i, wr_ready,  tbl[i].er);
            chk("wr_done",   i, wr_done,   tbl[i].ed);
            chk("ovf",       i, ovf,       tbl[i].eo);
        end

        // two held writes to the same register, then drain: last one wins
        hold = 1'b1; wr_valid = 1'b1; wr_addr = 3'd1; wr_data = 4'd1;
        @(posedge clk); #1;
        wr_data = 4'd2;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        chk("fill_pending", 100, pending, 2);
        chk("fill_ready", 100, wr_ready, 0);
        hold = 1'b0;
        begin
            int n = 0;
            while (pending != 3'd0 && n < 10) begin
                @(posedge clk); #1;
                n++;
            end
            chk("drain_timeout", 101, int'(n < 10), 1);
        end
        rd_addr_a = 3'd1;
        @(posedge clk); #1;
        chk("last_wins", 102, rd_data_a, 2);
        chk("drain_ready", 102, wr_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
